ibuf_serializer: RTL

Parametrised input buffer for the MAC array feed path. Packed words are queued in a DEPTH-entry FIFO and serialised one element per cycle onto a single lane. It supports back-to-back words with no bubbles, a downstream stall, selectable element order, and overflow flagging. It sits between the word-wide loader and the first PE row, and also forwards the Down enable as ENDown/ENToss.

---
 rtl/ibuf_serializer.sv | 114 +++++++++++
 1 files changed

// File: rtl/ibuf_serializer.sv
// Word-wide FIFO feeding a one-element-per-cycle serializer for the MAC array
// feed path; also forwards the Down enable one cycle later as ENDown/ENToss.
module ibuf_serializer #(
  parameter int EW        = 8,
  parameter int NE        = 4,
  parameter int DEPTH     = 4,
  parameter int LSB_FIRST = 0
) (
  input  logic                         CLK,
  input  logic                         RSTN,
  input  logic                         CLR,
  input  logic                         Write,
  input  logic [EW*NE-1:0]             IWord,
  input  logic                         Hold,
  input  logic                         Down,
  output logic                         WReady,
  output logic [EW-1:0]                OD,
  output logic                         OValid,
  output logic                         ENDown,
  output logic                         ENToss,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Busy,
  output logic                         Ovf
);

  localparam int W  = EW * NE;
  localparam int IW = $clog2(NE + 1);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [W-1:0]  cur_word;
  // idx == NE means no element of cur_word is pending (serializer idle).
  logic [IW-1:0] idx;
  logic          pending;
  logic          push;
  logic          pop;

  function automatic logic [EW-1:0] pick(input logic [W-1:0] w, input logic [IW-1:0] i);
    logic [EW-1:0] e;
    // NOTE: default assignment first so every path drives e; no latch can be inferred.
    e = '0;
    for (int k = 0; k < NE; k++) begin
      if (IW'(k) == i) e = (LSB_FIRST != 0) ? w[k*EW +: EW] : w[(NE-1-k)*EW +: EW];
    end
    return e;
  endfunction

  assign WReady  = (Count != DEPTH[$clog2(DEPTH+1)-1:0]);
  assign pending = (idx < IW'(NE));
  assign push    = !CLR && Write && WReady;
  assign pop     = !CLR && !Hold && !pending && (Count != '0);
  assign Busy    = (Count != '0) || pending;

  // NOTE: storage array has no reset; occupancy is tracked by Count/pointers, so
  // stale contents are never observable and the RAM stays reset-free.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= IWord;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      cur_word <= '0;
      idx      <= IW'(NE);
      OD       <= '0;
      OValid   <= 1'b0;
      ENDown   <= 1'b0;
      ENToss   <= 1'b0;
      Ovf      <= 1'b0;
    end else if (CLR) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      cur_word <= '0;
      idx      <= IW'(NE);
      OD       <= '0;
      OValid   <= 1'b0;
      ENDown   <= 1'b0;
      ENToss   <= 1'b0;
      Ovf      <= 1'b0;
    end else begin
      ENDown <= Down;
      ENToss <= Down;
      if (Write && !WReady) Ovf <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      Count <= Count + 1'b1;
      else if (pop && !push) Count <= Count - 1'b1;

      if (!Hold) begin
        if (pending) begin
          OD     <= pick(cur_word, idx);
          OValid <= 1'b1;
          idx    <= idx + IW'(1);
        end else if (Count != '0) begin
          cur_word <= mem[rd_ptr];
          OD       <= pick(mem[rd_ptr], IW'(0));
          OValid   <= 1'b1;
          idx      <= IW'(1);
        end else begin
          OD     <= '0;
          OValid <= 1'b0;
        end
      end
    end
  end

endmodule
